// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (odd when PARITY_ODD=1, even otherwise).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  localparam logic [2:0] STOP   = 3'd5;

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx: illegal parameter combination");
  end

  logic [2:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_end;
  logic                 accept;

  // The last stop tick doubles as an accept slot so frames can run back to back.
  assign stop_end = (state == STOP) && (stop_cnt == LAST_STOP) && tick;
  assign tx_ready = (state == IDLE) || stop_end;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= (^tx_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          // A tick on the accept edge is deliberately ignored; SYNC waits for the next one.
          if (accept) begin
            shift <= tx_data;
            state <= SYNC;
          end
        end
        SYNC: begin
          if (tick) begin
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            txd     <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt != LAST_BIT) begin
              txd     <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
`ifdef UART_TX_PARITY_EN
              txd   <= par_bit;
              state <= PARITY;
`else
              txd      <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (tx_valid) begin
                shift <= tx_data;
                txd   <= 1'b0;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1 even, 8N2 even, 8N1 odd) checked cycle by cycle
// against a frame model built from bit lists; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [2:0] vld;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] rdy;
  logic [2:0] done;
  logic [7:0] dat [3];

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int sync_hi  = 0;
  int got_len  = 0;
  int stop_of [3] = '{1, 2, 1};
  int odd_of  [3] = '{0, 0, 1};
  logic        exp_bits [$];
  logic [15:0] got_vec;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(done[0]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(done[1]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(done[2]));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, ecnt);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, ecnt);
    end
  endtask

  // One clock; tick is high on every edge whose index is a multiple of T.
  task automatic cyc();
    @(posedge clk);
    ecnt++;
    #1;
    tick = (((ecnt + 1) % T) == 0);
    #1;
  endtask

  // Frame model: list of line levels, one per bit period.
  function automatic void build_frame(input int inst, input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    int   ones;
    logic p;
`endif
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = ((ones % 2) == 1);
    if (odd_of[inst] == 1) p = !p;
    exp_bits.push_back(p);
`endif
    for (int i = 0; i < stop_of[inst]; i++) exp_bits.push_back(1'b1);
  endfunction

  // Accept from idle on an edge at phase `lead` after a tick, check the SYNC wait,
  // and return right after the start-bit edge.
  task automatic idle_accept(input int inst, input logic [7:0] d, input int lead);
    for (int g = 0; g < T && ((ecnt + 1) % T) != lead; g++) cyc();
    chk1("ready_idle", rdy[inst], 1'b1);
    vld[inst] = 1'b1;
    dat[inst] = d;
    cyc();
    vld[inst] = 1'b0;
    dat[inst] = 8'($urandom);
    sync_hi = 0;
    for (int j = 0; j < T - lead; j++) begin
      if (j > 0) cyc();
      chk1("sync_txd", txd[inst], 1'b1);
      chk1("sync_busy", busy[inst], 1'b1);
      chk1("sync_ready", rdy[inst], 1'b0);
      chk1("sync_done", done[inst], 1'b0);
      sync_hi += int'(txd[inst]);
    end
    cyc();
  endtask

  // Check a whole frame starting from the sample just after its start-bit edge.
  task automatic check_frame(input int inst, input logic [7:0] d, input bit chain,
                             input logic [7:0] nxt);
    int nb;
    build_frame(inst, d);
    nb = exp_bits.size();
    got_vec = '0;
    if (chain) begin
      vld[inst] = 1'b1;
      dat[inst] = nxt;
    end
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < T; c++) begin
        if (k > 0 || c > 0) cyc();
        chk1("frame_txd", txd[inst], exp_bits[k]);
        chk1("frame_busy", busy[inst], 1'b1);
        chk1("frame_ready", rdy[inst], (k == nb - 1) && (c == T - 1));
        if (k > 0 || c > 0) chk1("frame_done", done[inst], 1'b0);
        if (c == T / 2) got_vec[k] = txd[inst];
      end
    end
    got_len = nb;
    cyc();
    vld[inst] = 1'b0;
    dat[inst] = 8'($urandom);
    chk1("end_done", done[inst], 1'b1);
    if (chain) begin
      chk1("chain_start", txd[inst], 1'b0);
      chk1("chain_busy", busy[inst], 1'b1);
    end else begin
      chk1("end_txd", txd[inst], 1'b1);
      chk1("end_busy", busy[inst], 1'b0);
      chk1("end_ready", rdy[inst], 1'b1);
      cyc();
      chk1("done_pulse", done[inst], 1'b0);
      chk1("idle_txd", txd[inst], 1'b1);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    int inst;
    int lead;
    reset = 1'b1;
    tick  = 1'b0;
    vld   = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk1("rst_txd", txd[i], 1'b1);
      chk1("rst_busy", busy[i], 1'b0);
      chk1("rst_done", done[i], 1'b0);
      chk1("rst_ready", rdy[i], 1'b1);
    end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // 8N1 0xA5
    idle_accept(0, 8'hA5, 3);
    check_frame(0, 8'hA5, 1'b0, 8'h00);
`ifndef UART_TX_PARITY_EN
    chkw("a5_bits", 32'(got_vec[9:0]), 32'h34A);
`endif

    // Back-to-back 0x00 then 0xFF with tx_valid held
    idle_accept(0, 8'h00, 9);
    check_frame(0, 8'h00, 1'b1, 8'hFF);
    check_frame(0, 8'hFF, 1'b0, 8'h00);

    // Accept 5 clks after a tick: 11 clks of SYNC
    idle_accept(0, 8'h3C, 5);
    chkw("sync_len", 32'(sync_hi), 32'd11);
    check_frame(0, 8'h3C, 1'b0, 8'h00);

    // Accept on the tick edge itself: waits a full period in SYNC
    idle_accept(2, 8'hC3, 0);
    chkw("sync_len_t0", 32'(sync_hi), 32'd16);
    check_frame(2, 8'hC3, 1'b0, 8'h00);

    // Reset during data bit 3 of 0x55
    idle_accept(0, 8'h55, 7);
    for (int i = 0; i < 4 * T + 3; i++) cyc();
    chk1("abort_bit3", txd[0], 1'b0);
    reset = 1'b0;
    #1;
    chk1("abort_txd", txd[0], 1'b1);
    chk1("abort_busy", busy[0], 1'b0);
    chk1("abort_ready", rdy[0], 1'b1);
    chk1("abort_done", done[0], 1'b0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      cyc();
      chk1("post_abort_done", done[0], 1'b0);
      chk1("post_abort_txd", txd[0], 1'b1);
    end
    idle_accept(0, 8'h81, 2);
    check_frame(0, 8'h81, 1'b0, 8'h00);

    // Parity frames of 0x07 (even and odd instances)
    idle_accept(0, 8'h07, 4);
    check_frame(0, 8'h07, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
    chk1("par_even", got_vec[9], 1'b1);
    chkw("par_even_len", 32'(got_len), 32'd11);
`endif
    idle_accept(2, 8'h07, 11);
    check_frame(2, 8'h07, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
    chk1("par_odd", got_vec[9], 1'b0);
    chkw("par_odd_len", 32'(got_len), 32'd11);
`endif

    // Two stop bits, 0x0F
    idle_accept(1, 8'h0F, 6);
    check_frame(1, 8'h0F, 1'b0, 8'h00);
    chk1("stop2_a", got_vec[got_len - 1], 1'b1);
    chk1("stop2_b", got_vec[got_len - 2], 1'b1);
    chk1("stop2_lastdata", got_vec[8], 1'b0);

    // Randomised single frames and a randomised chain
    repeat (6) begin
      inst = int'($urandom_range(0, 2));
      d    = 8'($urandom);
      lead = int'($urandom_range(0, T - 1));
      idle_accept(inst, d, lead);
      check_frame(inst, d, 1'b0, 8'h00);
    end
    inst = int'($urandom_range(0, 2));
    d    = 8'($urandom);
    d2   = 8'($urandom);
    idle_accept(inst, d, int'($urandom_range(0, T - 1)));
    check_frame(inst, d, 1'b1, d2);
    check_frame(inst, d2, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
